// File: rtl/sdram_bist.sv
// SDRAM self-test sequencer: walks an address range in four passes (write P, check P,
// write ~P, check ~P) through the SdramCtrl request port and reports the outcome.
module sdram_bist #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              range_err,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              sdram_req,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rh_wl,
  output logic [DATA_W-1:0] sdram_data_w,
  input  logic              sdram_ack,
  input  logic [DATA_W-1:0] sdram_data_r,
  input  logic              sdram_data_r_en
);

  localparam int unsigned WdW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StReq    = 3'd1;
  localparam logic [2:0] StRdWait = 3'd2;
  localparam logic [2:0] StGap    = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam logic [1:0] PhW0 = 2'd0;
  localparam logic [1:0] PhR1 = 2'd3;

  logic [2:0]        state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [ADDR_W-1:0] cur_q, cur_d, lo_q, lo_d, hi_q, hi_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [WdW-1:0]    wdog_q, wdog_d, wdog_inc;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] fea_q, fea_d;
  logic [DATA_W-1:0] fed_q, fed_d;
  logic              tmo_q, tmo_d, rerr_q, rerr_d;
  logic              check;
  logic              is_read;
  logic [23:0]       cur24;
  logic [15:0]       addr_fold;
  logic [DATA_W-1:0] pat, expected;

  // Upper address byte is folded into both halves so every address bit affects the pattern.
  assign cur24     = 24'(cur_q);
  assign addr_fold = cur24[15:0] ^ {cur24[23:16], cur24[23:16]};
  assign pat       = seed_q ^ DATA_W'(addr_fold);
  assign expected  = phase_q[1] ? ~pat : pat;
  assign is_read   = phase_q[0];
  assign wdog_inc  = wdog_q + WdW'(1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cur_d   = cur_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    seed_d  = seed_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    fea_d   = fea_q;
    fed_d   = fed_q;
    tmo_d   = tmo_q;
    rerr_d  = rerr_q;
    check   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          lo_d   = addr_lo;
          hi_d   = addr_hi;
          seed_d = seed;
          err_d  = '0;
          fea_d  = '0;
          fed_d  = '0;
          tmo_d  = 1'b0;
          rerr_d = 1'b0;
          if (addr_hi < addr_lo) begin
            rerr_d  = 1'b1;
            state_d = StDone;
          end else begin
            phase_d = PhW0;
            cur_d   = addr_lo;
            wdog_d  = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        wdog_d = wdog_inc;
        if (sdram_ack) begin
          if (!is_read) begin
            state_d = StGap;
          end else if (sdram_data_r_en) begin
            check   = 1'b1;
            state_d = StGap;
          end else begin
            state_d = StRdWait;
          end
        end else if (wdog_inc == WdW'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end
      end
      StRdWait: begin
        wdog_d = wdog_inc;
        if (sdram_data_r_en) begin
          check   = 1'b1;
          state_d = StGap;
        end else if (wdog_inc == WdW'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end
      end
      StGap: begin
        // Equality end test lets addr_hi = all-ones finish without wrapping.
        if (cur_q != hi_q) begin
          cur_d   = cur_q + ADDR_W'(1);
          wdog_d  = '0;
          state_d = StReq;
        end else begin
          cur_d = lo_q;
          if (phase_q == PhR1) begin
            state_d = StDone;
          end else begin
            phase_d = phase_q + 2'd1;
            wdog_d  = '0;
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (check && (sdram_data_r != expected)) begin
      if (err_q == 16'h0000) begin
        fea_d = cur_q;
        fed_d = sdram_data_r;
      end
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= PhW0;
      cur_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      seed_q  <= '0;
      wdog_q  <= '0;
      err_q   <= '0;
      fea_q   <= '0;
      fed_q   <= '0;
      tmo_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cur_q   <= cur_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      seed_q  <= seed_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      fed_q   <= fed_d;
      tmo_q   <= tmo_d;
      rerr_q  <= rerr_d;
    end
  end

  assign busy           = (state_q == StReq) || (state_q == StRdWait) || (state_q == StGap);
  assign done           = (state_q == StDone);
  assign pass           = done && (err_q == 16'h0000) && !tmo_q && !rerr_q;
  assign timeout        = tmo_q;
  assign range_err      = rerr_q;
  assign err_count      = err_q;
  assign first_err_addr = fea_q;
  assign first_err_data = fed_q;
  assign sdram_req      = (state_q == StReq);
  assign sdram_addr     = sdram_req ? cur_q : '0;
  assign sdram_rh_wl    = sdram_req && is_read;
  assign sdram_data_w   = (sdram_req && !is_read) ? expected : '0;

endmodule

// File: tb/tb_sdram_bist.sv
// Bench for sdram_bist: SDRAM model with scoreboarded requests, table-driven test runs,
// plus hand-written watchdog and mid-test reset sequences.
module tb_sdram_bist;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] addr_lo, addr_hi;
  logic [15:0] seed;
  logic        busy, done, pass, timeout, range_err;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;
  logic [15:0] first_err_data;
  logic        sdram_req, sdram_rh_wl;
  logic [23:0] sdram_addr;
  logic [15:0] sdram_data_w;
  logic        sdram_ack = 1'b0;
  logic [15:0] sdram_data_r = '0;
  logic        sdram_data_r_en = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        rw;
    logic [23:0] addr;
    logic [15:0] data;
  } req_t;

  typedef struct {
    logic [23:0] lo;
    logic [23:0] hi;
    logic [15:0] seed;
    bit          stuck;
    int          lat;
    bit          poke;
    bit          exp_pass;
    logic [15:0] exp_errs;
    logic [23:0] exp_fa;
    logic [15:0] exp_fd;
    bit          exp_range;
  } vec_t;

  req_t        exp_q[$];
  logic [15:0] mem[logic [23:0]];
  bit          stuck_en = 1'b0;
  bit          no_ack = 1'b0;
  int          rd_lat = 0;
  int          lat_cnt = 0;
  logic [15:0] rd_hold = '0;
  logic        any_out;

  sdram_bist dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .addr_lo        (addr_lo),
    .addr_hi        (addr_hi),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .range_err      (range_err),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .sdram_req      (sdram_req),
    .sdram_addr     (sdram_addr),
    .sdram_rh_wl    (sdram_rh_wl),
    .sdram_data_w   (sdram_data_w),
    .sdram_ack      (sdram_ack),
    .sdram_data_r   (sdram_data_r),
    .sdram_data_r_en(sdram_data_r_en)
  );

  always #5 clk = ~clk;

  assign any_out = |{busy, done, pass, timeout, range_err, err_count, first_err_addr,
                     first_err_data, sdram_req, sdram_addr, sdram_rh_wl, sdram_data_w};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pattern(input logic [23:0] a, input logic [15:0] s);
    return s ^ a[15:0] ^ {a[23:16], a[23:16]};
  endfunction

  // Memory model: registered ack one cycle after req is seen, optional read latency.
  always @(posedge clk) begin
    logic [15:0] rd;
    req_t e;
    sdram_ack       <= 1'b0;
    sdram_data_r_en <= 1'b0;
    if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        sdram_data_r_en <= 1'b1;
        sdram_data_r    <= rd_hold;
      end
    end
    if (sdram_req && !sdram_ack && !no_ack) begin
      sdram_ack <= 1'b1;
      if (exp_q.size() == 0) begin
        check("sb_extra_req", 64'(sdram_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_req", 64'({sdram_rh_wl, sdram_addr, sdram_data_w}), 64'(e));
      end
      if (sdram_rh_wl) begin
        rd = mem.exists(sdram_addr) ? mem[sdram_addr] : 16'h0000;
        if (rd_lat == 0) begin
          sdram_data_r_en <= 1'b1;
          sdram_data_r    <= rd;
        end else begin
          lat_cnt <= rd_lat;
          rd_hold <= rd;
        end
      end else begin
        mem[sdram_addr] = (stuck_en && sdram_addr == 24'h000012) ?
                          (sdram_data_w & 16'hFFF7) : sdram_data_w;
      end
    end
  end

  task automatic push_expected(input vec_t v);
    logic [23:0] a;
    req_t r;
    for (int ph = 0; ph < 4; ph++) begin
      a = v.lo;
      while (1) begin
        r.rw   = ph[0];
        r.addr = a;
        r.data = ph[0] ? 16'h0000 : (ph >= 2 ? ~pattern(a, v.seed) : pattern(a, v.seed));
        exp_q.push_back(r);
        if (a == v.hi) break;
        a = a + 24'd1;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cycles;
    stuck_en = v.stuck;
    rd_lat   = v.lat;
    if (!v.exp_range) push_expected(v);
    @(negedge clk);
    addr_lo = v.lo;
    addr_hi = v.hi;
    seed    = v.seed;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!done && cycles < 3000) begin
      start = v.poke && (cycles == 5);
      if (start) begin
        addr_lo = 24'h000500;
        addr_hi = 24'h000400;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    if (v.exp_range) begin
      check({tag, "_range_latency"}, 64'(cycles), 64'd0);
      check({tag, "_range_noreq"}, 64'(sdram_req), 64'd0);
    end
    check({tag, "_pass"}, 64'(pass), 64'(v.exp_pass));
    check({tag, "_range_err"}, 64'(range_err), 64'(v.exp_range));
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'(v.exp_errs));
    check({tag, "_first_err_addr"}, 64'(first_err_addr), 64'(v.exp_fa));
    check({tag, "_first_err_data"}, 64'(first_err_data), 64'(v.exp_fd));
    check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got expired, want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    vec_t clean;
    int   cycles, reqc, nz;

    //            lo           hi           seed      stk lat poke pass errs   fa           fd       rng
    vecs[0] = '{24'h000010, 24'h000013, 16'h0000, 0, 0, 0, 1, 16'd0, 24'h000000, 16'h0000, 0};
    vecs[1] = '{24'h000010, 24'h000013, 16'h0000, 1, 0, 0, 0, 16'd1, 24'h000012, 16'hFFE5, 0};
    vecs[2] = '{24'h000020, 24'h00001F, 16'h0000, 0, 0, 0, 0, 16'd0, 24'h000000, 16'h0000, 1};
    vecs[3] = '{24'hFFFFFF, 24'hFFFFFF, 16'h1234, 0, 5, 0, 1, 16'd0, 24'h000000, 16'h0000, 0};
    vecs[4] = '{24'h01FFFE, 24'h020001, 16'hA5C3, 0, 2, 1, 1, 16'd0, 24'h000000, 16'h0000, 0};
    clean   = '{24'h000010, 24'h000013, 16'h5A5A, 0, 0, 0, 1, 16'd0, 24'h000000, 16'h0000, 0};

    reset   = 1'b1;
    start   = 1'b0;
    addr_lo = '0;
    addr_hi = '0;
    seed    = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", 64'(any_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs_zero", 64'(any_out), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Controller that never acknowledges: watchdog must cut the request.
    no_ack = 1'b1;
    @(negedge clk);
    addr_lo = 24'h000000;
    addr_hi = 24'h000003;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    reqc   = 0;
    while (!done && cycles < 3000) begin
      if (sdram_req) reqc++;
      @(negedge clk);
      cycles++;
    end
    check("wdog_req_cycles", 64'(reqc), 64'd1023);
    check("wdog_timeout", 64'(timeout), 64'd1);
    check("wdog_done", 64'(done), 64'd1);
    check("wdog_pass", 64'(pass), 64'd0);
    check("wdog_req_low", 64'(sdram_req), 64'd0);
    no_ack = 1'b0;

    // Reset in the middle of R0 while a read request is outstanding.
    stuck_en = 1'b0;
    rd_lat   = 3;
    push_expected(clean);
    addr_lo = clean.lo;
    addr_hi = clean.hi;
    seed    = clean.seed;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!(sdram_req && sdram_rh_wl) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("rst_reached_r0", 64'(sdram_req && sdram_rh_wl), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_outputs_zero", 64'(any_out), 64'd0);
    exp_q.delete();
    nz = 0;
    repeat (6) begin
      @(negedge clk);
      if (any_out) nz++;
    end
    check("rst_late_resp_ignored", 64'(nz), 64'd0);
    run_vec(clean, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_bist.md
Name: sdram_bist

Overview:
Self-contained SDRAM test sequencer that sits directly upstream of SdramCtrl and drives its request interface (sdram_req/ack/addr/rh_wl/data_w, sdram_data_r/_en). On start it walks an inclusive address range in four phases: write pattern P, read and check P, write ~P, read and check ~P. It counts mismatches, captures the first failure, and guards against a hung controller with a watchdog. Status outputs are intended for SpiPeek-style observation or LEDs.

Parameters:
ADDR_W, 24, SDRAM word-address width.
DATA_W, 16, SDRAM data width.
TIMEOUT, 1023, maximum number of cycles to wait for ack or read data before aborting.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a test; ignored while busy
addr_lo  in  ADDR_W  first address, inclusive; latched on start
addr_hi  in  ADDR_W  last address, inclusive; latched on start
seed  in  DATA_W  pattern seed; latched on start
busy  out  1  test in progress
done  out  1  test finished; held until the next start
pass  out  1  valid when done: 1 means no errors, no timeout and a valid range
timeout  out  1  watchdog abort occurred
range_err  out  1  addr_hi < addr_lo at start
err_count  out  16  mismatch count, saturating at 16'hFFFF
first_err_addr  out  ADDR_W  address of the first mismatch
first_err_data  out  DATA_W  data read at the first mismatch
sdram_req  out  1  request to SdramCtrl
sdram_addr  out  ADDR_W  request address
sdram_rh_wl  out  1  1 = read, 0 = write
sdram_data_w  out  DATA_W  write data
sdram_ack  in  1  one-cycle acceptance pulse from SdramCtrl
sdram_data_r  in  DATA_W  read data
sdram_data_r_en  in  1  one-cycle read-data-valid pulse

Behaviour:
- Clock and reset: clk is the only clock. reset is synchronous and active-high.
- Reset values: every output is 0, and the FSM goes to IDLE. sdram_ack and sdram_data_r_en arriving after reset for a transaction already in flight are ignored.
- FSM states: IDLE, REQ, RD_WAIT, GAP, DONE. A 2-bit phase register selects W0, R0, W1, R1.
- Start:
  - start in IDLE or DONE latches addr_lo, addr_hi and seed.
  - It clears err_count, first_err_*, timeout, range_err and done.
  - If addr_hi < addr_lo, the next cycle enters DONE with range_err=1 and pass=0. No sdram_req is issued.
  - Otherwise: phase=W0, cur=addr_lo, busy=1, and sdram_req rises on the cycle after start.
- Pattern:
  - P(a) = seed ^ a[15:0] ^ {a[23:16], a[23:16]}.
  - W0 and R0 use P(a). W1 and R1 use ~P(a).
- REQ state:
  - sdram_req=1. sdram_addr=cur, sdram_rh_wl = phase is R0 or R1, sdram_data_w = the pattern (0 in read phases).
  - All request outputs are held stable until sdram_ack is sampled high.
  - On ack in a write phase: go to GAP.
  - On ack in a read phase: go to RD_WAIT. If sdram_data_r_en is high in the same cycle as ack, check the data immediately and go to GAP.
  - sdram_req drops on the cycle after ack is sampled.
- RD_WAIT state: on sdram_data_r_en, compare sdram_data_r with the expected pattern, then go to GAP.
- On a mismatch:
  - err_count increments, saturating at 16'hFFFF.
  - If this is the first error, latch first_err_addr=cur and first_err_data=sdram_data_r.
- GAP state: exactly one idle cycle between requests (sdram_req=0).
  - If cur != addr_hi: increment cur and return to REQ.
  - Otherwise: reset cur to addr_lo and advance the phase.
  - After R1, go to DONE.
  - The end test uses an equality compare, so addr_hi=24'hFFFFFF terminates without wrapping.
- Watchdog:
  - The counter clears on entry to REQ and increments in REQ and RD_WAIT.
  - When it reaches TIMEOUT: timeout=1, sdram_req=0, go to DONE.
- DONE state: done=1, busy=0, pass = (err_count==0) & ~timeout & ~range_err. The state holds until start or reset.
- Signals outside their state: ack or data_r_en seen in IDLE, GAP or DONE is ignored. start while busy is ignored.
- Request rate: one outstanding request at a time. Minimum of 3 cycles per write and 3 per read.

Test Plan:
1. Ideal zero-latency memory model with seed=0, lo=0x000010, hi=0x000013, start → 16 requests in W0,R0,W1,R1 order; W0 data to 0x10 is 0x0010, W1 data is 0xFFEF; done=1, pass=1, err_count=0.
2. Same range, model with bit 3 stuck-0 at address 0x000012 → err_count=1, first_err_addr=0x000012, first_err_data=0xFFE5, pass=0.
3. Model that never asserts ack, TIMEOUT=1023 → sdram_req high for exactly 1023 cycles; then timeout=1, done=1, pass=0, sdram_req=0.
4. lo=0x000020, hi=0x00001F → range_err=1 and done one cycle after start; sdram_req never rises.
5. lo=hi=0xFFFFFF with read data arriving 5 cycles after ack → exactly 4 requests, then done with pass=1; no address wrap.
6. reset asserted during R0 while sdram_req=1 → next cycle all outputs are 0; a late ack/data_r_en is ignored; a new start runs a clean test with pass=1.
